// File: rtl/crypto_round_sequencer.sv
`default_nettype none
// ============================================================================
// crypto_round_sequencer
// Control sequencer that emits one-hot step strobes for an AES-style round datapath.
// Rev 1.0
// ============================================================================
module crypto_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 4,
  parameter int STEP_WAIT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] round,
  output logic [14:0]      ctrl
);

  localparam logic [3:0] c_LOAD        = 4'd0;
  localparam logic [3:0] c_ENC_AK0     = 4'd1;
  localparam logic [3:0] c_SAVE        = 4'd2;
  localparam logic [3:0] c_SUB         = 4'd3;
  localparam logic [3:0] c_SHIFT       = 4'd4;
  localparam logic [3:0] c_MIX         = 4'd5;
  localparam logic [3:0] c_KEY_EXP     = 4'd6;
  localparam logic [3:0] c_ADDKEY      = 4'd7;
  localparam logic [3:0] c_DEC_AK0     = 4'd8;
  localparam logic [3:0] c_INV_SHIFT   = 4'd9;
  localparam logic [3:0] c_INV_SUB     = 4'd10;
  localparam logic [3:0] c_INV_KEY_EXP = 4'd11;
  localparam logic [3:0] c_INV_MIX     = 4'd12;
  localparam logic [3:0] c_OUT_DATA    = 4'd13;
  localparam logic [3:0] c_OUT_KEY     = 4'd14;

  localparam logic             c_HAS_WAIT   = (STEP_WAIT != 0);
  localparam logic [3:0]       c_WAIT_LAST  = (STEP_WAIT > 0) ? 4'(STEP_WAIT - 1) : 4'd0;
  localparam logic [CNT_W-1:0] c_LAST_ROUND = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_WAIT, S_DONE} state_t;

  state_t             state_q;
  logic [3:0]         step_q, step_d;
  logic [3:0]         wait_q;
  logic [CNT_W-1:0]   round_q, round_d;
  logic               enc_q;
  logic               busy_q, done_q, err_q;
  logic [14:0]        ctrl_q;
  logic               last_step;
  logic               mode_ok;

  assign mode_ok = (mode == 2'b01) || (mode == 2'b10);

  // Successor of the current step; the round index moves only on the first strobe of a round.
  always_comb begin
    step_d    = step_q;
    round_d   = round_q;
    last_step = 1'b0;
    case (step_q)
      c_LOAD:        step_d = enc_q ? c_ENC_AK0 : c_DEC_AK0;
      c_ENC_AK0:     begin step_d = c_SAVE;      round_d = c_ONE;        end
      c_DEC_AK0:     begin step_d = c_INV_SHIFT; round_d = c_LAST_ROUND; end
      c_SAVE:        step_d = c_SUB;
      c_SUB:         step_d = c_SHIFT;
      c_SHIFT:       step_d = (round_q == c_LAST_ROUND) ? c_KEY_EXP : c_MIX;
      c_MIX:         step_d = c_KEY_EXP;
      c_KEY_EXP:     step_d = c_ADDKEY;
      c_ADDKEY: begin
        if (enc_q) begin
          if (round_q == c_LAST_ROUND) begin
            step_d = c_OUT_DATA;
          end else begin
            step_d  = c_SAVE;
            round_d = round_q + c_ONE;
          end
        end else begin
          step_d = (round_q == c_ONE) ? c_OUT_DATA : c_INV_MIX;
        end
      end
      c_INV_MIX:     begin step_d = c_INV_SHIFT; round_d = round_q - c_ONE; end
      c_INV_SHIFT:   step_d = c_INV_SUB;
      c_INV_SUB:     step_d = c_INV_KEY_EXP;
      c_INV_KEY_EXP: step_d = c_ADDKEY;
      c_OUT_DATA:    step_d = c_OUT_KEY;
      default:       last_step = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      step_q  <= c_LOAD;
      wait_q  <= 4'd0;
      round_q <= '0;
      enc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            if (mode_ok) begin
              state_q <= S_STEP;
              enc_q   <= (mode == 2'b01);
              step_q  <= c_LOAD;
              round_q <= '0;
              busy_q  <= 1'b1;
              ctrl_q  <= 15'(1) << c_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_STEP, S_WAIT: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            round_q <= '0;
            ctrl_q  <= '0;
            wait_q  <= 4'd0;
          end else if (state_q == S_STEP && c_HAS_WAIT) begin
            state_q <= S_WAIT;
            ctrl_q  <= '0;
            wait_q  <= c_WAIT_LAST;
          end else if (state_q == S_WAIT && wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else if (last_step) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            round_q <= '0;
            ctrl_q  <= '0;
          end else begin
            state_q <= S_STEP;
            step_q  <= step_d;
            round_q <= round_d;
            ctrl_q  <= 15'(1) << step_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          wait_q  <= 4'd0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign round = round_q;
  assign ctrl  = ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_crypto_round_sequencer.sv
`default_nettype none
// ============================================================================
// tb_crypto_round_sequencer
// Scoreboard bench: two instances (10 rounds / 1 wait, 1 round / no wait).
// Rev 1.0
// ============================================================================
module tb_crypto_round_sequencer;

  localparam int NR0 = 10;
  localparam int SW0 = 1;
  localparam int NR1 = 1;
  localparam int SW1 = 0;

  typedef struct {
    int          inst;
    int          cyc;
    logic [14:0] ctrl;
    logic [3:0]  round;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       start_v;
  logic [1:0][1:0]  mode_v;
  logic [1:0]       abort_v;
  logic [1:0]       busy_v, done_v, err_v;
  logic [1:0][3:0]  round_v;
  logic [1:0][14:0] ctrl_v;

  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crypto_round_sequencer #(.NUM_ROUNDS(NR0), .CNT_W(4), .STEP_WAIT(SW0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]), .abort(abort_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .round(round_v[0]), .ctrl(ctrl_v[0])
  );

  crypto_round_sequencer #(.NUM_ROUNDS(NR1), .CNT_W(4), .STEP_WAIT(SW1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]), .abort(abort_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .round(round_v[1]), .ctrl(ctrl_v[1])
  );

  // Reference: list the step names in spec order, then place them on the timeline.
  task automatic push_op(input int k, input bit enc, input int e0, input int cut);
    int   stp[$];
    int   rnd[$];
    int   enc_body[6] = '{2, 3, 4, 5, 6, 7};
    int   dec_body[5] = '{9, 10, 11, 7, 12};
    int   nr, sw, t;
    exp_t e;
    nr = (k == 0) ? NR0 : NR1;
    sw = (k == 0) ? SW0 : SW1;
    stp.push_back(0);             rnd.push_back(0);
    stp.push_back(enc ? 1 : 8);   rnd.push_back(0);
    if (enc) begin
      for (int r = 1; r <= nr; r++)
        foreach (enc_body[j])
          if (!(enc_body[j] == 5 && r == nr)) begin
            stp.push_back(enc_body[j]); rnd.push_back(r);
          end
    end else begin
      for (int r = nr; r >= 1; r--)
        foreach (dec_body[j])
          if (!(dec_body[j] == 12 && r == 1)) begin
            stp.push_back(dec_body[j]); rnd.push_back(r);
          end
    end
    stp.push_back(13); rnd.push_back(enc ? nr : 1);
    stp.push_back(14); rnd.push_back(enc ? nr : 1);
    foreach (stp[i]) begin
      t = e0 + i * (1 + sw);
      if (t <= cut) begin
        e.inst = k; e.cyc = t; e.ctrl = 15'(1) << stp[i]; e.round = 4'(rnd[i]);
        e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0;
        exp_q.push_back(e);
      end
    end
    t = e0 + stp.size() * (1 + sw);
    if (t <= cut) begin
      e.inst = k; e.cyc = t; e.ctrl = '0; e.round = '0;
      e.busy = 1'b0; e.done = 1'b1; e.err = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_quiet(input int k, input string name);
    n_tests++;
    if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || err_v[k] !== 1'b0 ||
        round_v[k] !== 4'd0 || ctrl_v[k] !== 15'd0) begin
      n_fail++;
      $display("FAIL %s inst=%0d cyc=%0d got busy=%b done=%b err=%b round=%0d ctrl=%h, need all zero",
               name, k, cyc, busy_v[k], done_v[k], err_v[k], round_v[k], ctrl_v[k]);
    end
  endtask

  task automatic check_drained(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected outputs never appeared (next due cyc=%0d inst=%0d ctrl=%h done=%b)",
               name, exp_q.size(), exp_q[0].cyc, exp_q[0].inst, exp_q[0].ctrl, exp_q[0].done);
      exp_q.delete();
    end
  endtask

  task automatic drive_idle(input int k);
    start_v[k] = 1'b0;
    abort_v[k] = 1'b0;
    mode_v[k]  = 2'b00;
  endtask

  // abort_req: -1 none, -2 random cycle, else offset from the accept edge.
  // rst_at: offset from the accept edge after which reset is pulsed mid-cycle, or -1.
  task automatic run_op(input int k, input logic [1:0] md, input int abort_req,
                        input int rst_at, input int hold);
    int nr, sw, s, lat, abort_at, e0, cut;
    bit valid, enc;
    exp_t e;
    nr    = (k == 0) ? NR0 : NR1;
    sw    = (k == 0) ? SW0 : SW1;
    valid = (md == 2'b01) || (md == 2'b10);
    enc   = (md == 2'b01);
    s     = enc ? (2 + 6 * nr - 1 + 2) : (2 + 5 * nr - 1 + 2);
    lat   = s * (1 + sw);
    if (hold > lat) hold = lat;
    abort_at = (abort_req == -2) ? int'($urandom_range(lat - 1, 0)) : abort_req;
    e0  = cyc + 1;
    cut = 1 << 30;
    if (abort_at >= 0) cut = e0 + abort_at;
    if (rst_at >= 0)   cut = e0 + rst_at;
    if (valid) begin
      push_op(k, enc, e0, cut);
    end else begin
      e.inst = k; e.cyc = e0; e.ctrl = '0; e.round = '0;
      e.busy = 1'b0; e.done = 1'b0; e.err = 1'b1;
      exp_q.push_back(e);
    end
    start_v[k] = 1'b1;
    mode_v[k]  = md;
    for (int t = 0; t <= lat + 1; t++) begin
      @(negedge clk);
      if ((!valid && t == 1) || (valid && abort_at >= 0 && t == abort_at + 1) || t == lat + 1) begin
        drive_idle(k);
        check_quiet(k, valid ? ((abort_at >= 0) ? "after_abort" : "after_done") : "after_err");
        check_drained("outputs_seen");
        break;
      end
      if (valid && t == rst_at) begin
        #2;
        rst = 1'b0;
        drive_idle(k);
        #1;
        check_quiet(k, "async_reset");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        break;
      end
      start_v[k] = valid && (t + 1 < hold);
      mode_v[k]  = 2'($urandom);
      abort_v[k] = (t == abort_at);
    end
  endtask

  // Monitor: every visible strobe, done or err must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst === 1'b1 && (ctrl_v[k] !== 15'd0 || done_v[k] !== 1'b0 || err_v[k] !== 1'b0)) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output inst=%0d cyc=%0d got ctrl=%h round=%0d busy=%b done=%b err=%b, need none",
                     k, cyc, ctrl_v[k], round_v[k], busy_v[k], done_v[k], err_v[k]);
          end else begin
            e = exp_q.pop_front();
            if (e.inst != k || e.cyc != cyc || e.ctrl !== ctrl_v[k] || e.round !== round_v[k] ||
                e.busy !== busy_v[k] || e.done !== done_v[k] || e.err !== err_v[k]) begin
              n_fail++;
              $display("FAIL output_event got inst=%0d cyc=%0d ctrl=%h round=%0d busy=%b done=%b err=%b; need inst=%0d cyc=%0d ctrl=%h round=%0d busy=%b done=%b err=%b",
                       k, cyc, ctrl_v[k], round_v[k], busy_v[k], done_v[k], err_v[k],
                       e.inst, e.cyc, e.ctrl, e.round, e.busy, e.done, e.err);
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic [1:0]  md;
    rst = 1'b0;
    drive_idle(0);
    drive_idle(1);
    repeat (3) @(negedge clk);
    check_quiet(0, "reset_state");
    check_quiet(1, "reset_state");
    rst = 1'b1;
    @(negedge clk);

    run_op(0, 2'b01, -1, -1, 1);       // full encrypt
    run_op(0, 2'b10, -1, -1, 3);       // full decrypt, start held a little
    run_op(0, 2'b11, -1, -1, 1);       // invalid mode
    run_op(0, 2'b00, -1, -1, 1);
    run_op(0, 2'b01, -1, -1, 1);       // valid start right after err

    start_v[0] = 1'b1; mode_v[0] = 2'b01; abort_v[0] = 1'b1;
    @(negedge clk);
    drive_idle(0);
    check_quiet(0, "abort_in_idle");

    run_op(0, 2'b01, 30, -1, 1);       // abort on round-3 SUB strobe
    run_op(0, 2'b01, -1, -1, 1);
    run_op(0, 2'b01, 124, -1, 1);      // abort on final strobe
    run_op(0, 2'b01, 125, -1, 1);      // abort on final wait cycle
    run_op(0, 2'b10, 105, -1, 1);
    run_op(0, 2'b10, -1, 40, 1);       // async reset mid-decrypt
    run_op(0, 2'b10, -1, -1, 1);

    run_op(1, 2'b01, -1, -1, 1000);    // one round, no wait, start held
    run_op(1, 2'b10, -1, -1, 1000);
    run_op(1, 2'b01, 4, -1, 1);
    run_op(1, 2'b01, 8, -1, 1);        // abort on OUT_KEY strobe
    run_op(1, 2'b10, -1, 3, 1);

    for (int i = 0; i < 12; i++) begin
      k  = int'($urandom_range(1, 0));
      md = 2'($urandom);
      run_op(k, md, ($urandom_range(2, 0) == 0) ? -2 : -1, -1, int'($urandom_range(6, 1)));
    end

    repeat (3) @(negedge clk);
    check_quiet(0, "final_idle");
    check_quiet(1, "final_idle");
    check_drained("final_scoreboard");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
